// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array controller and its issue queue:
// instruction width, opcode encodings and the issue-queue FSM state encoding.
package sa_ctrl_pkg;

  localparam int INSTR_W = 64;

  localparam logic [4:0] OP_NOP       = 5'b00000;
  localparam logic [4:0] OP_COMPUTE   = 5'b00001;
  localparam logic [4:0] OP_COMPUTE_I = 5'b00010;
  localparam logic [4:0] OP_ACC_TO_OB = 5'b00011;
  localparam logic [4:0] OP_LD_INP    = 5'b00100;
  localparam logic [4:0] OP_LD_WT     = 5'b00101;
  localparam logic [4:0] OP_OB_SEND   = 5'b00110;
  localparam logic [4:0] OP_ACC_RST   = 5'b00111;
  localparam logic [4:0] OP_HALT      = 5'b11111;

  typedef enum logic [1:0] {
    ST_ISSUE        = 2'd0,
    ST_WAIT_COMPUTE = 2'd1,
    ST_HALTED       = 2'd2
  } iq_state_t;

  // Opcodes that occupy the array until compute_done
  function automatic logic is_compute(input logic [4:0] op);
    return (op == OP_COMPUTE) || (op == OP_COMPUTE_I);
  endfunction

endpackage

// File: rtl/instr_issue_queue_if.sv
// Host-side and controller-side signals of the issue queue.
// master = host/controller side, slave = the queue itself.
interface instr_issue_queue_if #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 64
);
  logic [INSTR_W-1:0]     host_instr;
  logic                   host_valid;
  logic                   host_ready;
  logic [INSTR_W-1:0]     instruction;
  logic                   compute_done;
  logic                   resume;
  logic                   halted;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output host_instr, host_valid, compute_done, resume,
    input  host_ready, instruction, halted, busy, fifo_count
  );

  modport slave (
    input  host_instr, host_valid, compute_done, resume,
    output host_ready, instruction, halted, busy, fifo_count
  );
endinterface

// File: rtl/instr_issue_queue_sync_fifo.sv
// Single-clock FIFO: registered memory, wrapping pointers, occupancy count.
// Head word is read combinationally from mem[rd_ptr]; a word written at an
// edge is only visible as head after that edge (no write-to-read bypass).
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since pointers/count discard them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_issue_queue.sv
// Issue queue feeding the systolic-array controller. Pops one instruction
// per clock onto a registered output, issuing NOP while empty, while a
// compute op is running, or while halted after a HALT op.
module instr_issue_queue #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = sa_ctrl_pkg::INSTR_W
) (
  input logic               clk,
  input logic               rst,
  instr_issue_queue_if.slave bus
);
  import sa_ctrl_pkg::*;

  iq_state_t              state, state_nxt;
  logic [INSTR_W-1:0]     head, instr_q, instr_nxt;
  logic                   halted_q, halted_nxt;
  logic                   pop, full, empty;
  logic [$clog2(DEPTH):0] count;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.host_valid & ~full),
    .pop   (pop),
    .wdata (bus.host_instr),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // host_ready comes from the registered count only
  assign bus.host_ready  = ~full;
  assign bus.instruction = instr_q;
  assign bus.halted      = halted_q;
  assign bus.fifo_count  = count;
  assign bus.busy        = (state != ST_ISSUE) | ~empty;

  // Next state, pop decision and next output word
  always_comb begin
    state_nxt  = state;
    instr_nxt  = '0;
    halted_nxt = halted_q;
    pop        = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (!empty) begin
          pop       = 1'b1;
          instr_nxt = head;
          if (is_compute(head[4:0])) begin
            state_nxt = ST_WAIT_COMPUTE;
          end else if (head[4:0] == OP_HALT) begin
            state_nxt  = ST_HALTED;
            halted_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_COMPUTE: begin
        if (bus.compute_done) state_nxt = ST_ISSUE;
      end
      ST_HALTED: begin
        if (bus.resume) begin
          state_nxt  = ST_ISSUE;
          halted_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_ISSUE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ISSUE;
      instr_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      instr_q  <= instr_nxt;
      halted_q <= halted_nxt;
    end
  end
endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: reset idle, streaming, compute
// stall, full-queue backpressure with wrap, HALT/resume, mid-run reset.
module tb_instr_issue_queue;
  import sa_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int W     = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  instr_issue_queue_if #(.DEPTH(DEPTH), .INSTR_W(W)) bus();
  instr_issue_queue #(.DEPTH(DEPTH), .INSTR_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [31:0] t, input logic [4:0] op);
    return {27'd0, t, op};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] w [DEPTH];
    logic [63:0] extra;
    bus.host_instr   = '0;
    bus.host_valid   = 1'b0;
    bus.compute_done = 1'b0;
    bus.resume       = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_instr", bus.instruction, 64'h0);
      chk("idle_ready", bus.host_ready, 1);
      chk("idle_count", bus.fifo_count, 0);
      chk("idle_busy",  bus.busy, 0);
    end

    // 2: back-to-back pushes stream straight through
    bus.host_valid = 1'b1;
    bus.host_instr = mk(32'h11, OP_LD_INP);
    tick();
    chk("s2_e1_instr", bus.instruction, 64'h0);
    chk("s2_e1_count", bus.fifo_count, 1);
    bus.host_instr = mk(32'h22, OP_LD_WT);
    tick();
    chk("s2_e2_instr", bus.instruction, mk(32'h11, OP_LD_INP));
    chk("s2_e2_count", bus.fifo_count, 1);
    bus.host_valid = 1'b0;
    tick();
    chk("s2_e3_instr", bus.instruction, mk(32'h22, OP_LD_WT));
    chk("s2_e3_count", bus.fifo_count, 0);
    tick();
    chk("s2_e4_instr", bus.instruction, 64'h0);
    chk("s2_e4_busy",  bus.busy, 0);

    // 3: compute stalls issue until compute_done
    bus.host_valid = 1'b1;
    bus.host_instr = mk(32'h33, OP_COMPUTE);
    tick();
    bus.host_instr = mk(32'h44, OP_ACC_RST);
    tick();
    bus.host_valid = 1'b0;
    chk("s3_compute", bus.instruction, mk(32'h33, OP_COMPUTE));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s3_stall_instr", bus.instruction, 64'h0);
      chk("s3_stall_count", bus.fifo_count, 1);
      chk("s3_stall_busy",  bus.busy, 1);
    end
    bus.compute_done = 1'b1;
    tick();
    bus.compute_done = 1'b0;
    chk("s3_done_instr", bus.instruction, 64'h0);
    tick();
    chk("s3_accrst", bus.instruction, mk(32'h44, OP_ACC_RST));
    chk("s3_count0", bus.fifo_count, 0);
    tick();
    chk("s3_after", bus.instruction, 64'h0);

    // 4: fill to DEPTH while stalled, then drain in order across the wrap
    bus.host_valid = 1'b1;
    bus.host_instr = mk(32'h55, OP_COMPUTE_I);
    tick();
    bus.host_valid = 1'b0;
    tick();
    chk("s4_compute", bus.instruction, mk(32'h55, OP_COMPUTE_I));
    for (int i = 0; i < DEPTH; i++) w[i] = mk(32'h100 + i, 5'(3 + (i % 5)));
    bus.host_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.host_instr = w[i];
      chk("s4_ready_fill", bus.host_ready, 1);
      tick();
      chk("s4_fill_count", bus.fifo_count, 64'(i + 1));
    end
    chk("s4_ready_full", bus.host_ready, 0);
    extra = mk(32'hDEAD, OP_OB_SEND);
    bus.host_instr = extra;
    tick();
    chk("s4_full_count", bus.fifo_count, DEPTH);
    chk("s4_full_instr", bus.instruction, 64'h0);
    bus.host_valid = 1'b0;
    bus.compute_done = 1'b1;
    tick();
    bus.compute_done = 1'b0;
    chk("s4_release_count", bus.fifo_count, DEPTH);
    // full and popping in the same cycle: push must still be refused
    bus.host_valid = 1'b1;
    tick();
    bus.host_valid = 1'b0;
    chk("s4_pop_full_count", bus.fifo_count, DEPTH - 1);
    chk("s4_drain0", bus.instruction, w[0]);
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      chk("s4_drain", bus.instruction, w[i]);
      chk("s4_drain_count", bus.fifo_count, 64'(DEPTH - 1 - i));
    end
    tick();
    chk("s4_empty_instr", bus.instruction, 64'h0);
    chk("s4_empty_busy",  bus.busy, 0);

    // 5: HALT blocks until resume; compute_done ignored while halted
    bus.host_valid = 1'b1;
    bus.host_instr = mk(32'h66, OP_HALT);
    tick();
    bus.host_instr = mk(32'h77, OP_LD_INP);
    tick();
    bus.host_valid = 1'b0;
    chk("s5_halt_instr", bus.instruction, mk(32'h66, OP_HALT));
    chk("s5_halted", bus.halted, 1);
    chk("s5_count", bus.fifo_count, 1);
    bus.compute_done = 1'b1;
    tick();
    bus.compute_done = 1'b0;
    chk("s5_cd_instr", bus.instruction, 64'h0);
    chk("s5_cd_halted", bus.halted, 1);
    tick();
    chk("s5_hold_instr", bus.instruction, 64'h0);
    chk("s5_hold_count", bus.fifo_count, 1);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    chk("s5_resume_halted", bus.halted, 0);
    chk("s5_resume_instr", bus.instruction, 64'h0);
    tick();
    chk("s5_ldinp", bus.instruction, mk(32'h77, OP_LD_INP));
    tick();
    chk("s5_after", bus.instruction, 64'h0);

    // 6: asynchronous reset mid compute-wait with 5 queued words
    bus.host_valid = 1'b1;
    bus.host_instr = mk(32'h88, OP_COMPUTE);
    tick();
    bus.host_valid = 1'b0;
    tick();
    chk("s6_compute", bus.instruction, mk(32'h88, OP_COMPUTE));
    bus.host_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.host_instr = mk(32'h200 + i, OP_LD_WT);
      tick();
    end
    bus.host_valid = 1'b0;
    chk("s6_count5", bus.fifo_count, 5);
    chk("s6_busy", bus.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_instr", bus.instruction, 64'h0);
    chk("s6_rst_count", bus.fifo_count, 0);
    chk("s6_rst_halted", bus.halted, 0);
    chk("s6_rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    bus.host_valid = 1'b1;
    bus.host_instr = mk(32'h99, 5'b10101);
    tick();
    bus.host_valid = 1'b0;
    chk("s6_push_count", bus.fifo_count, 1);
    tick();
    chk("s6_unknown_op", bus.instruction, mk(32'h99, 5'b10101));
    tick();
    chk("s6_after", bus.instruction, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
